// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the RISC-V core front end.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer toward decode; supports push and pop together when full.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero before the first fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the fetch buffer, handles redirects and fetch faults.
//   state | meaning
//   FETCH | fetching sequentially, pushing words into the buffer
//   FAULT | fetch halted (sentinel word or misaligned redirect), buffer drains only
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] ERR_WORD = cpu_pkg::ERR_WORD,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  import cpu_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic         full, empty;
  logic         pop, push, space, err_hit;
  fetch_entry_t head, wentry;

  assign pop     = !empty && instr_ready;
  assign space   = !full || pop;
  assign err_hit = (imem_rdata == ERR_WORD);
  assign push    = (state == FETCH) && !redirect_valid && space && !err_hit;

  assign wentry.pc    = pc;
  assign wentry.instr = imem_rdata;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign imem_addr   = pc;
  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state    <= FAULT;
        fault    <= 1'b1;
        fault_pc <= redirect_pc;
      end else begin
        state    <= FETCH;
        fault    <= 1'b0;
        fault_pc <= '0;
      end
    end else begin
      case (state)
        FETCH: begin
          // The sentinel only faults when a push would otherwise have happened.
          if (space && err_hit) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
          end else if (push) begin
            pc <= pc + 32'd4;
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-based reference model plus directed literal checks.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_fpc;
  bit          m_fault;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0040_0000), .ERR_WORD(32'hDEAD_BEEF), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Program image: 41 words from 0x00400000, sentinel beyond; a small valid window at the top of memory.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] idx;
    if (a >= 32'hFFFF_FFF0) return 32'h0000_0013;
    if (a < 32'h0040_0000 || a >= 32'h0040_00A4) return 32'hDEAD_BEEF;
    idx = (a - 32'h0040_0000) >> 2;
    case (idx)
      32'd0:   return 32'h0010_0413;
      32'd1:   return 32'h0020_0493;
      32'd10:  return 32'h0094_0933;
      32'd40:  return 32'h4094_09B3;
      default: return 32'h0000_0013 | (idx << 20);
    endcase
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h0040_0000;
    m_fault = 0;
    m_fpc   = 32'h0;
  endtask

  // Spec-level behaviour of one rising edge.
  task automatic model_edge();
    logic [31:0] w;
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        m_fault = 1;
        m_fpc   = redirect_pc;
      end else begin
        m_fault = 0;
        m_fpc   = 32'h0;
      end
    end else begin
      if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
      if (!m_fault && mq.size() < DEPTH) begin
        w = imem_word(m_pc);
        if (w == 32'hDEAD_BEEF) begin
          m_fault = 1;
          m_fpc   = m_pc;
        end else begin
          mq.push_back('{pc: m_pc, ins: w});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic compare();
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() > 0});
    check("fault", {31'b0, fault}, {31'b0, m_fault});
    check("fault_pc", fault_pc, m_fpc);
    if (mq.size() > 0) begin
      check("instr", instr, mq[0].ins);
      check("instr_pc", instr_pc, mq[0].pc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, imem_addr, 32'h0040_0000);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_fault"}, {31'b0, fault}, 32'h0);
    check({tag, "_fault_pc"}, fault_pc, 32'h0);
  endtask

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 32'h0;
      if (redirect_valid) begin
        case ($urandom_range(0, 9))
          0:       redirect_pc = 32'h0040_0000 + 4 * $urandom_range(0, 42) + $urandom_range(1, 3);
          1:       redirect_pc = 32'hFFFF_FFF4;
          default: redirect_pc = 32'h0040_0000 + 4 * $urandom_range(0, 42);
        endcase
      end
      step();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] seen_a0;
    bit          faulted;
    seen_a0        = 32'h0;
    faulted        = 0;
    rst_n          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    model_reset();

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("hold_addr", imem_addr, 32'h0040_0008);
    check("hold_head_pc", instr_pc, 32'h0040_0000);
    check("hold_head", instr, 32'h0010_0413);

    instr_ready = 1'b1;
    step();
    check("seq1_pc", instr_pc, 32'h0040_0004);
    check("seq1_instr", instr, 32'h0020_0493);
    step();
    check("seq2_pc", instr_pc, 32'h0040_0008);

    for (int i = 0; i < 100 && !faulted; i++) begin
      step();
      if (instr_valid && instr_pc == 32'h0040_00A0) seen_a0 = instr;
      faulted = fault;
    end
    check("fault_reached", {31'b0, faulted}, 32'h1);
    check("fault_pc_oob", fault_pc, 32'h0040_00A4);
    check("last_before_fault", seen_a0, 32'h4094_09B3);
    step();
    check("drained_valid", {31'b0, instr_valid}, 32'h0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0028;
    step();
    redirect_valid = 1'b0;
    check("redir_fault_clr", {31'b0, fault}, 32'h0);
    check("redir_empty", {31'b0, instr_valid}, 32'h0);
    step();
    check("redir_pc", instr_pc, 32'h0040_0028);
    check("redir_instr", instr, 32'h0094_0933);

    instr_ready = 1'b0;
    repeat (3) step();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_000C;
    step();
    redirect_valid = 1'b0;
    check("full_redir_empty", {31'b0, instr_valid}, 32'h0);
    step();
    check("full_redir_pc", instr_pc, 32'h0040_000C);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0006;
    step();
    redirect_valid = 1'b0;
    check("misalign_fault", {31'b0, fault}, 32'h1);
    check("misalign_fault_pc", fault_pc, 32'h0040_0006);
    step();

    random_phase(1500);

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    step();
    check("restart_pc", instr_pc, 32'h0040_0000);

    random_phase(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
